// File: rtl/conv_job_arbiter_if.sv
// rtl/conv_job_arbiter_if.sv - requester and convolution-unit signal bundle for conv_job_arbiter
interface conv_job_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 9
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_x;
    logic [NUM_REQ*DATA_W-1:0] req_y;
    logic [NUM_REQ*DATA_W-1:0] req_z;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        cmp;
    logic [NUM_REQ-1:0]        to_err;
    logic                      conv_start;
    logic [DATA_W-1:0]         conv_x;
    logic [DATA_W-1:0]         conv_y;
    logic [DATA_W-1:0]         conv_z;
    logic                      conv_done;
    logic                      conv_abort;
    logic                      busy;
    logic [ID_W-1:0]           cur_id;

    modport slave (
        input  req, req_x, req_y, req_z, conv_done,
        output ack, cmp, to_err, conv_start, conv_x, conv_y, conv_z,
               conv_abort, busy, cur_id
    );

    modport master (
        output req, req_x, req_y, req_z, conv_done,
        input  ack, cmp, to_err, conv_start, conv_x, conv_y, conv_z,
               conv_abort, busy, cur_id
    );
endinterface

// File: rtl/conv_job_arbiter.sv
// rtl/conv_job_arbiter.sv - round-robin job arbiter for a shared convolution unit (optional watchdog: CONV_ARB_TIMEOUT_EN)
module conv_job_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 9,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    conv_job_arbiter_if.slave bus
);
    localparam int                ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W:0]     NUM_REQ_E = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ-1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] next_ptr;
    logic [ID_W:0]   idx;
    logic            found;

    // Search starts at rr_ptr and wraps at NUM_REQ, which need not be a power of two.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= NUM_REQ_E) idx = idx - NUM_REQ_E;
            if (!found && bus.req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (bus.cur_id == LAST_ID) ? '0 : bus.cur_id + 1'b1;

`ifdef CONV_ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign bus.to_err     = '0;
    assign bus.conv_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            bus.ack        <= '0;
            bus.cmp        <= '0;
            bus.conv_start <= 1'b0;
            bus.conv_x     <= '0;
            bus.conv_y     <= '0;
            bus.conv_z     <= '0;
            bus.busy       <= 1'b0;
            bus.cur_id     <= '0;
`ifdef CONV_ARB_TIMEOUT_EN
            bus.to_err     <= '0;
            bus.conv_abort <= 1'b0;
            to_cnt         <= '0;
`endif
        end else begin
            bus.ack        <= '0;
            bus.cmp        <= '0;
            bus.conv_start <= 1'b0;
`ifdef CONV_ARB_TIMEOUT_EN
            bus.to_err     <= '0;
            bus.conv_abort <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.conv_x     <= bus.req_x[int'(winner)*DATA_W +: DATA_W];
                        bus.conv_y     <= bus.req_y[int'(winner)*DATA_W +: DATA_W];
                        bus.conv_z     <= bus.req_z[int'(winner)*DATA_W +: DATA_W];
                        bus.cur_id     <= winner;
                        bus.ack        <= ONE_HOT0 << winner;
                        bus.conv_start <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                // conv_done may still be high from the previous job here, so it is not looked at.
                ISSUE: begin
                    state <= WAIT;
`ifdef CONV_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (bus.conv_done) begin
                        bus.cmp  <= ONE_HOT0 << bus.cur_id;
                        bus.busy <= 1'b0;
                        rr_ptr   <= next_ptr;
                        state    <= IDLE;
                    end
`ifdef CONV_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        bus.to_err     <= ONE_HOT0 << bus.cur_id;
                        bus.conv_abort <= 1'b1;
                        bus.busy       <= 1'b0;
                        rr_ptr         <= next_ptr;
                        state          <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_job_arbiter.sv
// tb/tb_conv_job_arbiter.sv - self-checking bench for conv_job_arbiter
module tb_conv_job_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 9;
    localparam int TIMEOUT_CYC = 8;
    localparam int LAT         = 3;

    logic clk = 1'b0;
    logic rst;

    conv_job_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    conv_job_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         win;
        logic [8:0] x;
        logic [8:0] y;
        logic [8:0] z;
    } vec_t;

    typedef struct {
        int         id;
        logic [8:0] x;
        logic [8:0] y;
        logic [8:0] z;
    } exp_t;

    exp_t sb[$];
    int   cmp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   auto_en = 1'b0;
    bit   outstanding = 1'b0;
    bit   saw_cmp1 = 1'b0;
    int   lat_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [8:0] opv(input int base, input int i, input int which);
        return 9'((base + i * 37 + which * 101) % 512);
    endfunction

    task automatic set_ops(input int base);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_x[i*DATA_W +: DATA_W] = opv(base, i, 0);
            bus.req_y[i*DATA_W +: DATA_W] = opv(base, i, 1);
            bus.req_z[i*DATA_W +: DATA_W] = opv(base, i, 2);
        end
    endtask

    task automatic push_exp(input int id, input int base);
        exp_t e;
        e.id = id;
        e.x  = opv(base, id, 0);
        e.y  = opv(base, id, 1);
        e.z  = opv(base, id, 2);
        sb.push_back(e);
    endtask

    // One clock: sample after the edge, score grants against the queue, then model the unit.
    task automatic tick();
        exp_t       e;
        logic [3:0] onehot;
        @(posedge clk);
        #1;
        check("exclusive", 64'((bus.ack & bus.cmp) | (bus.ack & bus.to_err) | (bus.cmp & bus.to_err)), 64'd0);
        if (bus.ack != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'(bus.ack), 64'd0);
            end else begin
                e = sb.pop_front();
                onehot = 4'b0001 << e.id;
                check("ack_id", 64'(bus.ack), 64'(onehot));
                check("cur_id", 64'(bus.cur_id), 64'(e.id));
                check("conv_x", 64'(bus.conv_x), 64'(e.x));
                check("conv_y", 64'(bus.conv_y), 64'(e.y));
                check("conv_z", 64'(bus.conv_z), 64'(e.z));
                check("conv_start", 64'(bus.conv_start), 64'd1);
                check("busy_on_ack", 64'(bus.busy), 64'd1);
                check("ack_after_cmp", 64'(outstanding), 64'd0);
            end
            outstanding = 1'b1;
        end
        if (bus.cmp != '0) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.cmp[i]) cmp_q.push_back(i);
            if (bus.cmp[1]) saw_cmp1 = 1'b1;
            outstanding = 1'b0;
        end
        if (bus.to_err != '0) outstanding = 1'b0;
        if (auto_en) begin
            if (bus.conv_done) bus.conv_done = 1'b0;
            if (bus.conv_start) lat_cnt = LAT;
            else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) bus.conv_done = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.conv_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        outstanding = 1'b0;
        sb.delete();
        cmp_q.delete();
        lat_cnt = 0;
    endtask

    task automatic wait_ack(input int bound, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.ack == '0 && lat < bound);
        check("ack_seen", 64'(bus.ack != '0), 64'd1);
    endtask

    task automatic wait_cmp(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.cmp == '0 && n < bound);
        check("cmp_seen", 64'(bus.cmp != '0), 64'd1);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.ack, bus.cmp, bus.to_err, bus.conv_start, bus.conv_x, bus.conv_y,
                    bus.conv_z, bus.conv_abort, bus.busy, bus.cur_id});
    endfunction

    vec_t vt[8];

    initial begin
        int lat;
        int n;
        int order[5];
        exp_t e;

        vt[0] = '{4'b0001, 0, 9'd20,  9'd284, 9'd300};
        vt[1] = '{4'b0101, 2, 9'd100, 9'd200, 9'd300};
        vt[2] = '{4'b0101, 0, 9'd511, 9'd0,   9'd256};
        vt[3] = '{4'b0101, 2, 9'd1,   9'd2,   9'd3};
        vt[4] = '{4'b1000, 3, 9'd77,  9'd88,  9'd99};
        vt[5] = '{4'b0110, 1, 9'd400, 9'd401, 9'd402};
        vt[6] = '{4'b0011, 0, 9'd123, 9'd321, 9'd213};
        vt[7] = '{4'b1111, 1, 9'd5,   9'd500, 9'd55};
        order = '{0, 1, 2, 3, 0};

        bus.req = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_z = '0;
        bus.conv_done = 1'b0;

        do_reset();
        check("reset_outputs", all_outs(), 64'd0);

        // Table: grant order from a known pointer, including the 3 -> 0 wrap with skips.
        auto_en = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_x[i*DATA_W +: DATA_W] = (i == vt[v].win) ? vt[v].x : vt[v].x ^ 9'(i + 1);
                bus.req_y[i*DATA_W +: DATA_W] = (i == vt[v].win) ? vt[v].y : vt[v].y ^ 9'(i + 1);
                bus.req_z[i*DATA_W +: DATA_W] = (i == vt[v].win) ? vt[v].z : vt[v].z ^ 9'(i + 1);
            end
            e.id = vt[v].win;
            e.x  = vt[v].x;
            e.y  = vt[v].y;
            e.z  = vt[v].z;
            sb.push_back(e);
            bus.req = vt[v].req;
            wait_ack(10, lat);
            check("ack_latency", 64'(lat), 64'd1);
            bus.req = '0;
            wait_cmp(20);
            check("cmp_id", 64'(bus.cmp), 64'(4'b0001 << vt[v].win));
            check("busy_after_cmp", 64'(bus.busy), 64'd0);
            check("x_held", 64'(bus.conv_x), 64'(vt[v].x));
            tick();
        end

        // All four requesting continuously after reset.
        do_reset();
        auto_en = 1'b1;
        set_ops(50);
        for (int k = 0; k < 5; k++) push_exp(order[k], 50);
        bus.req = 4'b1111;
        n = 0;
        while (cmp_q.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        bus.req = '0;
        tick();
        tick();
        check("contention_count", 64'(cmp_q.size()), 64'd5);
        for (int k = 0; k < 5 && k < cmp_q.size(); k++)
            check("contention_order", 64'(cmp_q[k]), 64'(order[k]));
        check("contention_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while requester 1's job is in WAIT.
        do_reset();
        auto_en = 1'b0;
        saw_cmp1 = 1'b0;
        set_ops(9);
        push_exp(1, 9);
        bus.req = 4'b0010;
        wait_ack(10, lat);
        bus.req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midjob_reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        outstanding = 1'b0;
        sb.delete();
        push_exp(2, 9);
        bus.req = 4'b0100;
        wait_ack(10, lat);
        check("post_reset_latency", 64'(lat), 64'd1);
        bus.req = '0;
        tick();
        bus.conv_done = 1'b1;
        wait_cmp(5);
        check("post_reset_cmp", 64'(bus.cmp), 64'b0100);
        bus.conv_done = 1'b0;
        check("no_cmp1", 64'(saw_cmp1), 64'd0);
        tick();

        // conv_done high during ISSUE must not complete the job.
        do_reset();
        auto_en = 1'b0;
        set_ops(200);
        push_exp(0, 200);
        bus.req = 4'b0001;
        wait_ack(10, lat);
        bus.req = '0;
        bus.conv_done = 1'b1;
        tick();
        check("stale_cmp_issue", 64'(bus.cmp), 64'd0);
        bus.conv_done = 1'b0;
        tick();
        check("stale_cmp_wait", 64'(bus.cmp), 64'd0);
        check("stale_busy", 64'(bus.busy), 64'd1);
        bus.conv_done = 1'b1;
        tick();
        check("stale_real_cmp", 64'(bus.cmp), 64'b0001);
        bus.conv_done = 1'b0;
        tick();

`ifdef CONV_ARB_TIMEOUT_EN
        do_reset();
        auto_en = 1'b0;
        set_ops(300);
        push_exp(0, 300);
        push_exp(1, 300);
        bus.req = 4'b0011;
        wait_ack(10, lat);
        bus.req = 4'b0010;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.to_err == '0 && n < 20);
        check("to_delay", 64'(n), 64'(TIMEOUT_CYC + 1));
        check("to_err", 64'(bus.to_err), 64'b0001);
        check("to_abort", 64'(bus.conv_abort), 64'd1);
        check("to_no_cmp", 64'(bus.cmp), 64'd0);
        check("to_busy", 64'(bus.busy), 64'd0);
        wait_ack(5, lat);
        check("to_next_latency", 64'(lat), 64'd1);
        bus.req = '0;
        bus.conv_done = 1'b1;
        wait_cmp(5);
        check("to_next_cmp", 64'(bus.cmp), 64'b0010);
        bus.conv_done = 1'b0;
        tick();
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
